// File: rtl/branch_pkg.sv
// Jump-type and PC-source encodings shared by the branch controller and its bench.
package branch_pkg;
   localparam logic [2:0] JT_NONE = 3'b000;
   localparam logic [2:0] JT_JZ   = 3'b001;
   localparam logic [2:0] JT_JNZ  = 3'b010;
   localparam logic [2:0] JT_JC   = 3'b011;
   localparam logic [2:0] JT_JNC  = 3'b100;
   localparam logic [2:0] JT_JMP  = 3'b101;
   localparam logic [2:0] JT_CALL = 3'b110;
   localparam logic [2:0] JT_RET  = 3'b111;

   localparam logic [1:0] SRC_SEQ = 2'b00;
   localparam logic [1:0] SRC_RET = 2'b01;
   localparam logic [1:0] SRC_BR  = 2'b10;
   localparam logic [1:0] SRC_JMP = 2'b11;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address storage: write pointer, occupancy count, full/empty.
// Top of stack is wp-1; a push while full overwrites the oldest entry.
module ras_stack #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [ADDR_W-1:0]            i_wdata,
   output logic [ADDR_W-1:0]            o_top,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wp;
   logic [CW-1:0]     r_count;
   logic [PW-1:0]     w_top_idx;

   assign w_top_idx = r_wp - PW'(1);
   assign o_top     = r_mem[w_top_idx];
   assign o_count   = r_count;
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);

   // Storage is intentionally not reset; only pointer and count are.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wp] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_count <= '0;
      end else if (i_push) begin
         r_wp <= r_wp + PW'(1);
         if (r_count != CW'(DEPTH)) r_count <= r_count + CW'(1);
      end else if (i_pop) begin
         r_wp    <= r_wp - PW'(1);
         r_count <= r_count - CW'(1);
      end
   end
endmodule

// File: rtl/branch_ctrl_ras.sv
// Branch controller with integrated return-address stack and sticky error flags.
// Define RAS_WRAP_EN to let CALL on a full stack overwrite the oldest entry.
module branch_ctrl_ras
   import branch_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid,
   input  logic [2:0]                   j_type,
   input  logic                         c,
   input  logic                         z,
   input  logic [ADDR_W-1:0]            ret_in,
   input  logic                         clr_err,
   output logic [1:0]                   addr_src,
   output logic [ADDR_W-1:0]            ret_addr,
   output logic                         push,
   output logic                         pop,
   output logic [$clog2(DEPTH+1)-1:0]   sp_count,
   output logic                         stack_full,
   output logic                         stack_empty,
   output logic                         overflow,
   output logic                         underflow
);
   logic       w_push;
   logic       w_pop;
   logic       w_ovf_evt;
   logic       w_unf_evt;
   logic [1:0] w_src;
   logic       w_full;
   logic       w_empty;
   logic       r_overflow;
   logic       r_underflow;

   always_comb begin
      w_src     = SRC_SEQ;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_ovf_evt = 1'b0;
      w_unf_evt = 1'b0;
      if (valid) begin
         case (j_type)
            JT_JZ:   w_src = z  ? SRC_BR : SRC_SEQ;
            JT_JNZ:  w_src = !z ? SRC_BR : SRC_SEQ;
            JT_JC:   w_src = c  ? SRC_BR : SRC_SEQ;
            JT_JNC:  w_src = !c ? SRC_BR : SRC_SEQ;
            JT_JMP:  w_src = SRC_JMP;
            JT_CALL: begin
               w_src = SRC_JMP;
               if (w_full) begin
                  w_ovf_evt = 1'b1;
`ifdef RAS_WRAP_EN
                  w_push = 1'b1;
`else
                  w_push = 1'b0;
`endif
               end else begin
                  w_push = 1'b1;
               end
            end
            JT_RET: begin
               if (w_empty) begin
                  w_unf_evt = 1'b1;
               end else begin
                  w_src = SRC_RET;
                  w_pop = 1'b1;
               end
            end
            default: w_src = SRC_SEQ;
         endcase
      end
   end

   ras_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (ret_in),
      .o_top   (ret_addr),
      .o_count (sp_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A new error event in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= w_ovf_evt | (r_overflow  & ~clr_err);
         r_underflow <= w_unf_evt | (r_underflow & ~clr_err);
      end
   end

   assign addr_src    = w_src;
   assign push        = w_push;
   assign pop         = w_pop;
   assign stack_full  = w_full;
   assign stack_empty = w_empty;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
endmodule
